// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: PC stage states, fault codes, vectors.
// Imported by the program-counter stage and its next-PC selector.
package mips_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_LIMIT    = 2'b01;
  localparam logic [1:0] FLT_MISALIGN = 2'b10;

  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int unsigned LIMIT_DEF     = 32764;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with alignment and address-limit screening.
// Purely combinational; the caller decides whether to commit.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  EXC_VEC = WIDTH'(EXC_VEC_DEF),
  parameter int unsigned       LIMIT   = LIMIT_DEF
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             exc_i,
  output logic [WIDTH-1:0] cand_o,
  output logic             take_update_o,
  output logic [1:0]       fault_next_o
);

  // One extra bit so LIMIT = 2**WIDTH is representable.
  localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);

  logic misal;
  logic over;

  always_comb begin
    cand_o = pc_i + WIDTH'(4);
    priority case (1'b1)
      exc_i:          cand_o = EXC_VEC;
      jump_i:         cand_o = jump_target_i;
      branch_taken_i: cand_o = branch_target_i;
      default:        cand_o = pc_i + WIDTH'(4);
    endcase
  end

  assign take_update_o = exc_i | ~stall_i;
  assign misal         = |cand_o[1:0];
  assign over          = {1'b0, cand_o} >= LIM;

  always_comb begin
    fault_next_o = FLT_NONE;
    if (misal)
      fault_next_o = FLT_MISALIGN;
    else if (over)
      fault_next_o = FLT_LIMIT;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: BOOT bubble, RUN fetch, sticky HALT on fault.
// pc and pc_plus4 are registered together so they never disagree.
module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
  parameter int unsigned      LIMIT     = LIMIT_DEF,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pc_valid,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] p4_q, p4_d;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] cand;
  logic             take;
  logic [1:0]       fault_nx;

  pc_next_sel #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC),
    .LIMIT   (LIMIT)
  ) u_sel (
    .pc_i            (pc_q),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .exc_i           (exc),
    .cand_o          (cand),
    .take_update_o   (take),
    .fault_next_o    (fault_nx)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    p4_d    = p4_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (take) begin
          if (fault_nx != FLT_NONE) begin
            state_d = PC_HALT;
            fault_d = fault_nx;
          end else begin
            pc_d  = cand;
            p4_d  = cand + WIDTH'(4);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PC_HALT: state_d = PC_HALT;
      default: state_d = PC_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VEC;
      p4_q    <= RESET_VEC + WIDTH'(4);
      fault_q <= FLT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      p4_q    <= p4_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = p4_q;
  assign pc_valid    = (state_q == PC_RUN);
  assign halted      = (state_q == PC_HALT);
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus random traffic,
// two parametrisations checked against a behavioural model.
module tb_pc_unit;

  logic        clk = 0;
  logic        rst = 0;
  logic        stall = 0;
  logic        br = 0;
  logic [31:0] bt = 0;
  logic        jmp = 0;
  logic [31:0] jt = 0;
  logic        exc = 0;

  logic [31:0] pc0, p40, cnt0;
  logic        v0, h0;
  logic [1:0]  f0;
  logic [15:0] pc1, p41;
  logic [31:0] cnt1;
  logic        v1, h1;
  logic [1:0]  f1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_unit u_dut32 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(br), .branch_target(bt),
    .jump(jmp), .jump_target(jt), .exc(exc),
    .pc(pc0), .pc_plus4(p40), .pc_valid(v0),
    .halted(h0), .fault(f0), .fetch_count(cnt0)
  );

  pc_unit #(
    .WIDTH(16), .RESET_VEC(16'h0000),
    .EXC_VEC(16'h0180), .LIMIT(32'h1000), .CNT_W(32)
  ) u_dut16 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(br), .branch_target(bt[15:0]),
    .jump(jmp), .jump_target(jt[15:0]), .exc(exc),
    .pc(pc1), .pc_plus4(p41), .pc_valid(v1),
    .halted(h1), .fault(f1), .fetch_count(cnt1)
  );

  // Reference model: 0=boot 1=run 2=halt
  logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] m_lim  [2] = '{32'd32764, 32'h0000_1000};
  int          m_st   [2];
  logic [31:0] m_pc   [2];
  logic [1:0]  m_flt  [2];
  logic [31:0] m_cnt  [2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic [31:0] c;
    if (rst) begin
      m_st[i] = 0; m_pc[i] = 0; m_flt[i] = 0; m_cnt[i] = 0;
    end else if (m_st[i] == 0) begin
      m_st[i] = 1;
    end else if (m_st[i] == 1 && (exc || !stall)) begin
      if (exc) c = 32'h180;
      else if (jmp) c = jt & m_mask[i];
      else if (br) c = bt & m_mask[i];
      else c = (m_pc[i] + 4) & m_mask[i];
      if (c % 4 != 0) begin
        m_st[i] = 2; m_flt[i] = 2;
      end else if (c >= m_lim[i]) begin
        m_st[i] = 2; m_flt[i] = 1;
      end else begin
        m_pc[i] = c; m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] p,
                          input logic [31:0] p4, input logic v,
                          input logic h, input logic [1:0] f,
                          input logic [31:0] c);
    string s;
    s = $sformatf("i%0d", i);
    check({s, "_pc"}, p, m_pc[i]);
    check({s, "_pc4"}, p4, (m_pc[i] + 4) & m_mask[i]);
    check({s, "_valid"}, 32'(v), 32'(m_st[i] == 1));
    check({s, "_halt"}, 32'(h), 32'(m_st[i] == 2));
    check({s, "_fault"}, 32'(f), 32'(m_flt[i]));
    check({s, "_cnt"}, c, m_cnt[i]);
  endtask

  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [31:0] btg, input logic j,
                     input logic [31:0] jtg, input logic e);
    rst = r; stall = s; br = b; bt = btg;
    jmp = j; jt = jtg; exc = e;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cmp_inst(0, pc0, p40, v0, h0, f0, cnt0);
    cmp_inst(1, 32'(pc1), 32'(p41), v1, h1, f1, cnt1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] tg;
  int mode;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_pc[i] = 0; m_flt[i] = 0; m_cnt[i] = 0;
    end
    @(negedge clk);

    // reset and free run
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("rst_pc", pc0, 32'h0);
    check("rst_valid", 32'(v0), 32'h0);
    idle(4);
    check("seq_pc12", pc0, 32'd12);
    check("seq_cnt3", cnt0, 32'd3);

    // jump beats branch at pc=8
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("at_pc8", pc0, 32'd8);
    cyc(0, 0, 1, 32'h40, 1, 32'h100, 0);
    check("jmp_win", pc0, 32'h100);
    idle(1);
    check("jmp_next", pc0, 32'h104);

    // stall holds, exc beats stall
    cyc(0, 0, 0, 0, 1, 32'h20, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1, 32'h60, 0);
    check("stall_pc", pc0, 32'h20);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check("exc_pc", pc0, 32'h180);

    // misaligned jump halts; later jumps ignored
    cyc(0, 0, 0, 0, 1, 32'h102, 0);
    check("mis_fault", 32'(f0), 32'h2);
    check("mis_pc", pc0, 32'h180);
    cyc(0, 0, 0, 0, 1, 32'h200, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("halt_hold", pc0, 32'h180);
    cyc(1, 0, 0, 0, 1, 32'h200, 0);
    check("halt_rst", 32'(h0), 32'h0);

    // sequential walk into the limit
    idle(1);
    cyc(0, 0, 0, 0, 1, 32'd32756, 0);
    idle(1);
    check("lim_pc", pc0, 32'd32760);
    idle(1);
    check("lim_fault", 32'(f0), 32'h1);
    check("lim_hold", pc0, 32'd32760);

    // reset mid-run beats branch
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 1, 32'h40, 0);
    cyc(1, 0, 1, 32'h80, 0, 0, 0);
    check("midrst_pc", pc0, 32'h0);
    check("midrst_v", 32'(v0), 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      mode = $urandom_range(0, 19);
      if (mode == 0) tg = $urandom & 32'h7FFF;
      else if (mode == 1) tg = 32'd32764 + 4 * $urandom_range(0, 4);
      else if (mode < 5) tg = 4 * $urandom_range(0, 8190);
      else tg = 4 * $urandom_range(0, 1023);
      cyc($urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 20, tg,
          $urandom_range(0, 99) < 12,
          ($urandom_range(0, 1) == 0) ? tg : 4 * $urandom_range(0, 1023),
          $urandom_range(0, 99) < 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
